// File: rtl/control_main.sv
// rtl/control_main.sv - RV32I multicycle control FSM (Moore) driving datapath strobes and selects
//
// Ports:
//   clk           in   1  rising-edge clock
//   rst           in   1  synchronous active-high reset
//   opcode        in   7  instruction opcode from IR
//   funct3        in   3  instruction funct3 from IR
//   funct7        in   7  instruction funct7 from IR
//   zero_flag     in   1  combinational ALU zero flag
//   adr_src       out  1  memory address source (0=PC, 1=out bus)
//   pc_write      out  1  PC write strobe
//   ir_write      out  1  IR / old-PC write strobe
//   mem_write     out  1  memory write strobe
//   reg_write     out  1  register-file write strobe
//   output_en     out  1  output buffer enable
//   out_mux_sel   out  3  out bus source (0=ALU reg, 1=ALU direct, 2=data reg)
//   imm_sel       out  3  immediate format (0=I, 1=S, 2=B, 3=U, 4=J)
//   alu_src_a_sel out  2  ALU A source (0=old PC, 1=PC, 2=A reg)
//   alu_src_b_sel out  2  ALU B source (0=B reg, 1=imm, 2=const 4)
//   alu_ctrl      out  4  ALU operation
module control_main (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  input  logic       zero_flag,
  output logic       adr_src,
  output logic       pc_write,
  output logic       ir_write,
  output logic       mem_write,
  output logic       reg_write,
  output logic       output_en,
  output logic [2:0] out_mux_sel,
  output logic [2:0] imm_sel,
  output logic [1:0] alu_src_a_sel,
  output logic [1:0] alu_src_b_sel,
  output logic [3:0] alu_ctrl
);

  // FSM state encoding
  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_EXECR    = 4'd6;
  localparam logic [3:0] S_EXECI    = 4'd7;
  localparam logic [3:0] S_ALUWB    = 4'd8;
  localparam logic [3:0] S_BRANCH   = 4'd9;
  localparam logic [3:0] S_JAL      = 4'd10;
  localparam logic [3:0] S_JALR     = 4'd11;
  localparam logic [3:0] S_JALRJ    = 4'd12;
  localparam logic [3:0] S_LUI      = 4'd13;
  localparam logic [3:0] S_AUIPC    = 4'd14;

  // Opcodes
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  // ALU operations
  localparam logic [3:0] ALU_ADD    = 4'd0;
  localparam logic [3:0] ALU_SUB    = 4'd1;
  localparam logic [3:0] ALU_AND    = 4'd2;
  localparam logic [3:0] ALU_OR     = 4'd3;
  localparam logic [3:0] ALU_XOR    = 4'd4;
  localparam logic [3:0] ALU_SLL    = 4'd5;
  localparam logic [3:0] ALU_SRL    = 4'd6;
  localparam logic [3:0] ALU_SRA    = 4'd7;
  localparam logic [3:0] ALU_SLT    = 4'd8;
  localparam logic [3:0] ALU_SLTU   = 4'd9;
  localparam logic [3:0] ALU_PASS_B = 4'd10;

  // Immediate formats
  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_U = 3'd3;
  localparam logic [2:0] IMM_J = 3'd4;

  // Source selects
  localparam logic [1:0] A_OLDPC = 2'd0;
  localparam logic [1:0] A_PC    = 2'd1;
  localparam logic [1:0] A_REG   = 2'd2;
  localparam logic [1:0] B_REG   = 2'd0;
  localparam logic [1:0] B_IMM   = 2'd1;
  localparam logic [1:0] B_FOUR  = 2'd2;
  localparam logic [2:0] OM_ALUREG = 3'd0;
  localparam logic [2:0] OM_ALU    = 3'd1;
  localparam logic [2:0] OM_DATA   = 3'd2;

  logic [3:0] state_q;
  logic [3:0] state_d;

  // Only funct7[5] carries meaning for RV32I base ops.
  logic unused_funct7;
  assign unused_funct7 = ^{funct7[6], funct7[4:0]};

  // funct3/funct7 ALU decode shared by register and immediate forms.
  // Immediate forms have no SUB: funct7 bits there are immediate bits,
  // so funct3=000 ignores funct7[5] unless is_r is set. Shifts keep the
  // funct7[5] SRA/SRL split in both forms.
  function automatic logic [3:0] alu_decode(input logic [2:0] f3,
                                            input logic       f7b5,
                                            input logic       is_r);
    logic [3:0] op;
    case (f3)
      3'b000:  op = (is_r && f7b5) ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = f7b5 ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  // Next-state logic
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LOAD,
          OP_STORE:  state_d = S_MEMADR;
          OP_R:      state_d = S_EXECR;
          OP_I:      state_d = S_EXECI;
          OP_BRANCH: state_d = S_BRANCH;
          OP_JAL:    state_d = S_JAL;
          OP_JALR:   state_d = S_JALR;
          OP_LUI:    state_d = S_LUI;
          OP_AUIPC:  state_d = S_AUIPC;
          default:   state_d = S_FETCH;  // unsupported opcode retires as a NOP
        endcase
      end
      S_MEMADR:   state_d = (opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  state_d = S_MEMWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: state_d = S_FETCH;
      S_EXECR:    state_d = S_ALUWB;
      S_EXECI:    state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BRANCH:   state_d = S_FETCH;
      S_JAL:      state_d = S_ALUWB;
      S_JALR:     state_d = S_JALRJ;
      S_JALRJ:    state_d = S_ALUWB;
      S_LUI:      state_d = S_ALUWB;
      S_AUIPC:    state_d = S_ALUWB;
      default:    state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Output decode
  always_comb begin
    adr_src       = 1'b0;
    pc_write      = 1'b0;
    ir_write      = 1'b0;
    mem_write     = 1'b0;
    reg_write     = 1'b0;
    output_en     = 1'b0;
    out_mux_sel   = OM_ALUREG;
    imm_sel       = IMM_I;
    alu_src_a_sel = A_OLDPC;
    alu_src_b_sel = B_REG;
    alu_ctrl      = ALU_ADD;

    case (state_q)
      S_FETCH: begin
        ir_write      = 1'b1;
        pc_write      = 1'b1;
        alu_src_a_sel = A_PC;
        alu_src_b_sel = B_FOUR;
        out_mux_sel   = OM_ALU;
      end
      S_DECODE: begin
        // Precompute oldPC+imm so branch/jump targets sit in the ALU register.
        alu_src_a_sel = A_OLDPC;
        alu_src_b_sel = B_IMM;
        imm_sel       = (opcode == OP_JAL) ? IMM_J : IMM_B;
      end
      S_MEMADR: begin
        alu_src_a_sel = A_REG;
        alu_src_b_sel = B_IMM;
        imm_sel       = (opcode == OP_STORE) ? IMM_S : IMM_I;
      end
      S_MEMREAD: begin
        adr_src     = 1'b1;
        out_mux_sel = OM_ALUREG;
      end
      S_MEMWB: begin
        out_mux_sel = OM_DATA;
        reg_write   = 1'b1;
        output_en   = 1'b1;
      end
      S_MEMWRITE: begin
        adr_src     = 1'b1;
        out_mux_sel = OM_ALUREG;
        mem_write   = 1'b1;
      end
      S_EXECR: begin
        alu_src_a_sel = A_REG;
        alu_src_b_sel = B_REG;
        alu_ctrl      = alu_decode(funct3, funct7[5], 1'b1);
      end
      S_EXECI: begin
        alu_src_a_sel = A_REG;
        alu_src_b_sel = B_IMM;
        imm_sel       = IMM_I;
        alu_ctrl      = alu_decode(funct3, funct7[5], 1'b0);
      end
      S_ALUWB: begin
        out_mux_sel = OM_ALUREG;
        reg_write   = 1'b1;
        output_en   = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a_sel = A_REG;
        alu_src_b_sel = B_REG;
        alu_ctrl      = ALU_SUB;
        out_mux_sel   = OM_ALUREG;  // target precomputed in DECODE
        case (funct3)
          3'b000:  pc_write = zero_flag;
          3'b001:  pc_write = ~zero_flag;
          default: pc_write = 1'b0;
        endcase
      end
      S_JAL, S_JALRJ: begin
        // PC takes the held target while the ALU forms oldPC+4 for rd.
        alu_src_a_sel = A_OLDPC;
        alu_src_b_sel = B_FOUR;
        out_mux_sel   = OM_ALUREG;
        pc_write      = 1'b1;
      end
      S_JALR: begin
        alu_src_a_sel = A_REG;
        alu_src_b_sel = B_IMM;
        imm_sel       = IMM_I;
      end
      S_LUI: begin
        alu_src_b_sel = B_IMM;
        imm_sel       = IMM_U;
        alu_ctrl      = ALU_PASS_B;
      end
      S_AUIPC: begin
        alu_src_a_sel = A_OLDPC;
        alu_src_b_sel = B_IMM;
        imm_sel       = IMM_U;
      end
      default: begin
      end
    endcase

    // Reset kills every strobe immediately so an interrupted instruction
    // cannot complete a write in the cycle reset arrives.
    if (rst) begin
      pc_write  = 1'b0;
      ir_write  = 1'b0;
      mem_write = 1'b0;
      reg_write = 1'b0;
      output_en = 1'b0;
    end
  end

endmodule

// File: tb/tb_control_main.sv
// tb/tb_control_main.sv - table-driven scoreboard bench for control_main
module tb_control_main;

  logic       clk;
  logic       rst;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       zero_flag;
  logic       adr_src, pc_write, ir_write, mem_write, reg_write, output_en;
  logic [2:0] out_mux_sel, imm_sel;
  logic [1:0] alu_src_a_sel, alu_src_b_sel;
  logic [3:0] alu_ctrl;

  control_main dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .zero_flag(zero_flag), .adr_src(adr_src), .pc_write(pc_write),
    .ir_write(ir_write), .mem_write(mem_write), .reg_write(reg_write),
    .output_en(output_en), .out_mux_sel(out_mux_sel), .imm_sel(imm_sel),
    .alu_src_a_sel(alu_src_a_sel), .alu_src_b_sel(alu_src_b_sel),
    .alu_ctrl(alu_ctrl)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {adr, pcw, irw, mw, rw, oe, out_mux[3], imm[3], a[2], b[2], alu[4]}
  function automatic logic [19:0] mk(input logic adr, pcw, irw, mw, rw, oe,
                                     input logic [2:0] om, imm,
                                     input logic [1:0] a, b,
                                     input logic [3:0] alu);
    return {adr, pcw, irw, mw, rw, oe, om, imm, a, b, alu};
  endfunction

  localparam logic [19:0] STROBES = 20'h7C000;

  typedef struct packed {
    logic [6:0]       op;
    logic [2:0]       f3;
    logic [6:0]       f7;
    logic             z;
    logic [2:0]       n;
    logic [4:0][19:0] exp;
  } vec_t;

  vec_t        tbl[$];
  logic [19:0] sb[$];
  int          total = 0;
  int          bad = 0;

  logic [19:0] W_F, W_DB, W_DJ, W_AWB, W_MAI, W_MAS, W_MRD, W_MWB, W_MWR;
  logic [19:0] W_JAL, W_JALR, W_LUI, W_AUI;

  function automatic logic [19:0] w_execr(input logic [3:0] alu);
    return mk(0,0,0,0,0,0, 0,0, 2,0, alu);
  endfunction
  function automatic logic [19:0] w_execi(input logic [3:0] alu);
    return mk(0,0,0,0,0,0, 0,0, 2,1, alu);
  endfunction
  function automatic logic [19:0] w_br(input logic pcw);
    return mk(0,pcw,0,0,0,0, 0,0, 2,0, 4'd1);
  endfunction

  function automatic logic [19:0] dut_word();
    return {adr_src, pc_write, ir_write, mem_write, reg_write, output_en,
            out_mux_sel, imm_sel, alu_src_a_sel, alu_src_b_sel, alu_ctrl};
  endfunction

  task automatic add_vec(input logic [6:0] op, input logic [2:0] f3,
                         input logic [6:0] f7, input logic z, input logic [2:0] n,
                         input logic [19:0] e0, e1, e2, e3, e4);
    vec_t v;
    v.op = op; v.f3 = f3; v.f7 = f7; v.z = z; v.n = n;
    v.exp[0] = e0; v.exp[1] = e1; v.exp[2] = e2; v.exp[3] = e3; v.exp[4] = e4;
    tbl.push_back(v);
  endtask

  task automatic check(input string name, input logic [19:0] act, input logic [19:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%05h want=%05h", name, act, exp);
    end
  endtask

  // Pop one expected word from the scoreboard and compare against the DUT now.
  task automatic sb_step(input string name);
    logic [19:0] e;
    #1;
    if (sb.size() == 0) begin
      total++; bad++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      e = sb.pop_front();
      check(name, dut_word(), e);
    end
  endtask

  task automatic drive(input vec_t v);
    opcode = v.op; funct3 = v.f3; funct7 = v.f7; zero_flag = v.z;
    for (int k = 0; k < int'(v.n); k++) sb.push_back(v.exp[k]);
  endtask

  // Runs one instruction; entered and left at a negedge while in FETCH.
  task automatic run_vec(input vec_t v, input string tag);
    drive(v);
    for (int k = 0; k < int'(v.n); k++) begin
      sb_step($sformatf("%s.c%0d", tag, k));
      @(negedge clk);
    end
  endtask

  // Runs the first `stop` cycles of v, then asserts reset in cycle `stop`.
  task automatic reset_mid(input vec_t v, input int stop, input string tag);
    drive(v);
    for (int k = 0; k <= stop; k++) begin
      sb_step($sformatf("%s.c%0d", tag, k));
      if (k < stop) @(negedge clk);
    end
    sb.delete();
    rst = 1'b1;
    #1;
    check({tag, ".rst_strobes"}, dut_word() & STROBES, 20'h0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: timeout reached");
    $fatal(1, "timeout");
  end

  initial begin
    W_F    = mk(0,1,1,0,0,0, 1,0, 1,2, 0);
    W_DB   = mk(0,0,0,0,0,0, 0,2, 0,1, 0);
    W_DJ   = mk(0,0,0,0,0,0, 0,4, 0,1, 0);
    W_AWB  = mk(0,0,0,0,1,1, 0,0, 0,0, 0);
    W_MAI  = mk(0,0,0,0,0,0, 0,0, 2,1, 0);
    W_MAS  = mk(0,0,0,0,0,0, 0,1, 2,1, 0);
    W_MRD  = mk(1,0,0,0,0,0, 0,0, 0,0, 0);
    W_MWB  = mk(0,0,0,0,1,1, 2,0, 0,0, 0);
    W_MWR  = mk(1,0,0,1,0,0, 0,0, 0,0, 0);
    W_JAL  = mk(0,1,0,0,0,0, 0,0, 0,2, 0);
    W_JALR = mk(0,0,0,0,0,0, 0,0, 2,1, 0);
    W_LUI  = mk(0,0,0,0,0,0, 0,3, 0,1, 4'd10);
    W_AUI  = mk(0,0,0,0,0,0, 0,3, 0,1, 0);

    // 0: add x3,x1,x2 (0x002081B3)
    add_vec(7'b0110011, 3'b000, 7'h00, 0, 4, W_F, W_DB, w_execr(0), W_AWB, 0);
    add_vec(7'b0110011, 3'b000, 7'h20, 0, 4, W_F, W_DB, w_execr(1), W_AWB, 0);
    add_vec(7'b0110011, 3'b001, 7'h00, 0, 4, W_F, W_DB, w_execr(5), W_AWB, 0);
    add_vec(7'b0110011, 3'b010, 7'h00, 1, 4, W_F, W_DB, w_execr(8), W_AWB, 0);
    add_vec(7'b0110011, 3'b011, 7'h00, 0, 4, W_F, W_DB, w_execr(9), W_AWB, 0);
    add_vec(7'b0110011, 3'b100, 7'h00, 0, 4, W_F, W_DB, w_execr(4), W_AWB, 0);
    add_vec(7'b0110011, 3'b101, 7'h00, 0, 4, W_F, W_DB, w_execr(6), W_AWB, 0);
    add_vec(7'b0110011, 3'b101, 7'h20, 0, 4, W_F, W_DB, w_execr(7), W_AWB, 0);
    add_vec(7'b0110011, 3'b110, 7'h00, 0, 4, W_F, W_DB, w_execr(3), W_AWB, 0);
    add_vec(7'b0110011, 3'b111, 7'h00, 0, 4, W_F, W_DB, w_execr(2), W_AWB, 0);
    // immediates: addi with funct7[5]=1 stays ADD, srai, slti
    add_vec(7'b0010011, 3'b000, 7'h20, 0, 4, W_F, W_DB, w_execi(0), W_AWB, 0);
    add_vec(7'b0010011, 3'b101, 7'h20, 0, 4, W_F, W_DB, w_execi(7), W_AWB, 0);
    add_vec(7'b0010011, 3'b010, 7'h00, 0, 4, W_F, W_DB, w_execi(8), W_AWB, 0);
    // lw then sw
    add_vec(7'b0000011, 3'b010, 7'h00, 0, 5, W_F, W_DB, W_MAI, W_MRD, W_MWB);
    add_vec(7'b0100011, 3'b010, 7'h00, 0, 4, W_F, W_DB, W_MAS, W_MWR, 0);
    // branches
    add_vec(7'b1100011, 3'b000, 7'h00, 1, 3, W_F, W_DB, w_br(1), 0, 0);
    add_vec(7'b1100011, 3'b000, 7'h00, 0, 3, W_F, W_DB, w_br(0), 0, 0);
    add_vec(7'b1100011, 3'b001, 7'h00, 1, 3, W_F, W_DB, w_br(0), 0, 0);
    add_vec(7'b1100011, 3'b001, 7'h00, 0, 3, W_F, W_DB, w_br(1), 0, 0);
    add_vec(7'b1100011, 3'b100, 7'h00, 1, 3, W_F, W_DB, w_br(0), 0, 0);
    // jumps and upper immediates
    add_vec(7'b1101111, 3'b000, 7'h00, 0, 4, W_F, W_DJ, W_JAL, W_AWB, 0);
    add_vec(7'b1100111, 3'b000, 7'h00, 0, 5, W_F, W_DB, W_JALR, W_JAL, W_AWB);
    add_vec(7'b0110111, 3'b000, 7'h00, 0, 4, W_F, W_DB, W_LUI, W_AWB, 0);
    add_vec(7'b0010111, 3'b000, 7'h00, 0, 4, W_F, W_DB, W_AUI, W_AWB, 0);
    // unsupported opcodes retire in 2 cycles
    add_vec(7'b0000000, 3'b000, 7'h00, 0, 2, W_F, W_DB, 0, 0, 0);
    add_vec(7'b1111111, 3'b111, 7'h7F, 1, 2, W_F, W_DB, 0, 0, 0);

    rst = 1'b1; opcode = 7'b0110011; funct3 = 3'b000; funct7 = 7'h00; zero_flag = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    check("reset_strobes", dut_word() & STROBES, 20'h0);
    rst = 1'b0;

    foreach (tbl[i]) run_vec(tbl[i], $sformatf("v%0d", i));

    // Reset during MEMWRITE of sw (index 14), resumes with add (index 0).
    reset_mid(tbl[14], 3, "rst_memwrite");
    run_vec(tbl[0], "post_rst_memwrite");
    // Reset during ALUWB of add, resumes with beq taken (index 15).
    reset_mid(tbl[0], 3, "rst_aluwb");
    run_vec(tbl[15], "post_rst_aluwb");
    // Reset while in DECODE of lw, resumes with jalr.
    reset_mid(tbl[13], 1, "rst_decode");
    run_vec(tbl[21], "post_rst_decode");

    if (sb.size() != 0) begin
      total++; bad++;
      $display("FAIL scoreboard_leftover: got=%0d want=0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
